// File: rtl/btn_debounce_pkg.sv
// Shared types for the button debouncer: per-channel FSM state encoding.
// Synchronizer depth follows BTN_DEBOUNCE_SYNC_EN (2 flops when defined, else 1).
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_WAIT_HIGH = 2'b01,
        ST_HIGH      = 2'b10,
        ST_WAIT_LOW  = 2'b11
    } btn_state_t;

`ifdef BTN_DEBOUNCE_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif

    function automatic logic is_high(input btn_state_t st);
        return (st == ST_HIGH) || (st == ST_WAIT_LOW);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: input sampler, stability counter, FSM, edge pulses.
// BTN_DEBOUNCE_SYNC_EN selects a 2-flop synchronizer instead of one register.
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int NB_DBC     = 20,
    parameter int DBC_CYCLES = 1000000
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_btn,
    output logic o_btn_rise,
    output logic o_btn_fall
);

    localparam logic [NB_DBC-1:0] CNT_LAST = NB_DBC'(DBC_CYCLES - 1);
    localparam logic [NB_DBC-1:0] CNT_ONE  = NB_DBC'(1);

    btn_state_t        state_q, state_d;
    logic [NB_DBC-1:0] cnt_q, cnt_d;
    logic              s;
    logic              btn_d, rise_d, fall_d;

`ifdef BTN_DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) sync_q <= '0;
        else          sync_q <= {sync_q[0], i_btn};
    end

    assign s = sync_q[1];
`else
    logic sync_q;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) sync_q <= 1'b0;
        else          sync_q <= i_btn;
    end

    assign s = sync_q;
`endif

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_LOW;
            cnt_q      <= '0;
            o_btn      <= 1'b0;
            o_btn_rise <= 1'b0;
            o_btn_fall <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_btn      <= btn_d;
            o_btn_rise <= rise_d;
            o_btn_fall <= fall_d;
        end
    end

    // The counter holds the number of consecutive opposite samples seen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_LOW: begin
                if (s) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_WAIT_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        btn_d  = is_high(state_d);
        rise_d = btn_d && !is_high(state_q);
        fall_d = !btn_d && is_high(state_q);
    end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer: NB_BUTTONS independent btn_debounce_ch.
// BTN_DEBOUNCE_SYNC_EN enables 2-flop input synchronizers in every channel.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NB_BUTTONS = 4,
    parameter int NB_DBC     = 20,
    parameter int DBC_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic [NB_BUTTONS-1:0] i_btn,
    output logic [NB_BUTTONS-1:0] o_btn,
    output logic [NB_BUTTONS-1:0] o_btn_rise,
    output logic [NB_BUTTONS-1:0] o_btn_fall
);

    for (genvar g = 0; g < NB_BUTTONS; g++) begin : g_ch
        btn_debounce_ch #(
            .NB_DBC     (NB_DBC),
            .DBC_CYCLES (DBC_CYCLES)
        ) u_ch (
            .clock      (clock),
            .i_reset    (i_reset),
            .i_btn      (i_btn[g]),
            .o_btn      (o_btn[g]),
            .o_btn_rise (o_btn_rise[g]),
            .o_btn_fall (o_btn_fall[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (DBC_CYCLES=4, NB_DBC=4, 4 channels).
// Works with or without BTN_DEBOUNCE_SYNC_EN.
module tb_btn_debounce;

    localparam int NB  = 4;
    localparam int DBC = 4;
`ifdef BTN_DEBOUNCE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 1;
`endif
    localparam int LAT = SYNC + DBC;

    typedef struct packed {
        logic [NB-1:0] btn;
        logic [NB-1:0] rise;
        logic [NB-1:0] fall;
    } exp_t;

    logic          clock;
    logic          i_reset;
    logic [NB-1:0] i_btn;
    logic [NB-1:0] o_btn;
    logic [NB-1:0] o_btn_rise;
    logic [NB-1:0] o_btn_fall;

    int checks = 0;
    int errors = 0;

    exp_t          exp_q[$];
    logic [NB-1:0] dly_q[$];
    logic [NB-1:0] lvl;
    int            run[NB];

    btn_debounce #(
        .NB_BUTTONS (NB),
        .NB_DBC     (4),
        .DBC_CYCLES (DBC)
    ) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_btn      (i_btn),
        .o_btn      (o_btn),
        .o_btn_rise (o_btn_rise),
        .o_btn_fall (o_btn_fall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: a level flips once DBC consecutive sampled values disagree with it.
    always @(posedge clock) begin
        exp_t          e;
        logic [NB-1:0] s;
        e = '0;
        if (!i_reset) begin
            lvl = '0;
            for (int c = 0; c < NB; c++) run[c] = 0;
            dly_q.delete();
            for (int k = 0; k < SYNC; k++) dly_q.push_back('0);
        end else begin
            s = dly_q.pop_front();
            dly_q.push_back(i_btn);
            for (int c = 0; c < NB; c++) begin
                if (s[c] != lvl[c]) begin
                    run[c]++;
                    if (run[c] == DBC) begin
                        lvl[c] = s[c];
                        run[c] = 0;
                        if (s[c]) e.rise[c] = 1'b1;
                        else      e.fall[c] = 1'b1;
                    end
                end else begin
                    run[c] = 0;
                end
            end
            e.btn = lvl;
        end
        exp_q.push_back(e);
    end

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (!i_reset) e = '0;
            checks++;
            if (o_btn !== e.btn || o_btn_rise !== e.rise || o_btn_fall !== e.fall) begin
                errors++;
                $display("FAIL sb t=%0t got btn=%b rise=%b fall=%b want btn=%b rise=%b fall=%b",
                         $time, o_btn, o_btn_rise, o_btn_fall, e.btn, e.rise, e.fall);
            end
        end
    end

    task automatic cyc(input logic [NB-1:0] v, input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
            i_btn = v;
        end
    endtask

    // Counts edges until o_btn[ch] reaches lv; the stimulus was just driven.
    task automatic lat(input int ch, input logic lv, input int want, input string name);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clock);
            n++;
            #1;
            if (o_btn[ch] === lv) break;
        end
        checks++;
        if (n != want) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, n, want);
        end
    endtask

    initial begin
        int hold;
        logic [NB-1:0] v;
        i_reset = 1'b0;
        i_btn   = '0;
        repeat (3) @(posedge clock);
        #2;
        i_reset = 1'b1;
        cyc('0, 3);

        // clean press and release on channel 0
        cyc(4'b0001, 1);
        lat(0, 1'b1, LAT, "press");
        cyc(4'b0001, 8);
        cyc(4'b0000, 1);
        lat(0, 1'b0, LAT, "release");
        cyc(4'b0000, 6);

        // glitch on channel 1
        cyc(4'b0010, 3);
        cyc(4'b0000, 10);

        // all channels together
        cyc(4'b1111, 1);
        lat(3, 1'b1, LAT, "simul");
        cyc(4'b1111, 6);
        cyc(4'b0000, 12);

        // reset during debounce of channel 2
        cyc(4'b0100, 3);
        @(posedge clock);
        #2;
        i_reset = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        i_reset = 1'b1;
        lat(2, 1'b1, LAT, "rst_mid");
        cyc(4'b0100, 6);
        cyc(4'b0000, 10);

        // random bouncy traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            v    = NB'($urandom);
            hold = $urandom_range(1, 7);
            cyc(v, hold);
            if ($urandom_range(0, 39) == 0) begin
                @(posedge clock);
                #2;
                i_reset = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #2;
                i_reset = 1'b1;
            end
        end
        cyc('0, 12);
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
